// File: rtl/act_serializer.sv
// Activation serializer: unpacks a DATA_W*WORDS vector into DATA_W words, MSB slice first,
// with a valid/ready handshake on both sides.
module act_serializer #(
    parameter int DATA_W = 16,
    parameter int WORDS  = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W*WORDS-1:0]  in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     busy
);

    localparam int PW = DATA_W * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_vec;

    logic w_out_hs;
    logic w_final_hs;
    logic w_load;

    assign out_valid  = (r_state == S_SEND);
    assign busy       = out_valid;
    assign out_last   = out_valid && (r_cnt == LAST);
    assign w_out_hs   = out_valid & out_ready;
    assign w_final_hs = w_out_hs & out_last;
    // A new vector may enter while the final word of the current one leaves.
    assign in_ready   = (r_state == S_IDLE) | w_final_hs;
    assign w_load     = in_valid & in_ready;

    // The current word always sits in the top slice; the register is cleared when idle.
    assign out_data   = r_vec[PW-1 -: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_vec   <= '0;
        end else if (w_load) begin
            r_state <= S_SEND;
            r_cnt   <= '0;
            r_vec   <= in_data;
        end else if (w_final_hs) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_vec   <= '0;
        end else if (w_out_hs) begin
            r_cnt   <= r_cnt + CW'(1);
            r_vec   <= r_vec << DATA_W;
        end
    end

endmodule

// File: tb/tb_act_serializer.sv
// Directed self-checking bench for act_serializer at default parameters.
module tb_act_serializer;

    localparam int DW = 16;
    localparam int NW = 36;
    localparam int PW = DW * NW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [PW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0] lb;
    logic [PW-1:0] v1;
    logic [PW-1:0] v2;

    act_serializer #(.DATA_W(DW), .WORDS(NW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mkvec(input logic [DW-1:0] base);
        logic [PW-1:0] v;
        v = '0;
        for (int k = 0; k < NW; k++) v[(NW-k)*DW-1 -: DW] = base + DW'(k);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; words handshaken at that edge shift into the loop-back register.
    task automatic tick();
        logic          hs;
        logic [DW-1:0] d;
        hs = out_valid & out_ready & ~rst;
        d  = out_data;
        @(posedge clk);
        #1;
        if (hs) lb = {lb[PW-DW-1:0], d};
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        lb        = '0;
        v1        = mkvec(16'h0100);
        v2        = mkvec(16'h0200);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // Single vector, out_ready held high, loop-back reconstruction
        lb        = '0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = v1;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        for (int k = 0; k < NW; k++) begin
            check("t1_valid", 32'(out_valid), 32'd1);
            check("t1_data",  32'(out_data),  32'h0100 + 32'(k));
            check("t1_last",  32'(out_last),  32'(k == NW-1));
            check("t1_ready", 32'(in_ready),  32'(k == NW-1));
            tick();
        end
        check("t1_end_valid", 32'(out_valid), 32'd0);
        check("t1_end_data",  32'(out_data),  32'd0);
        check_w("t1_loopback", lb, v1);

        // Same vector, out_ready toggling every cycle
        in_valid = 1'b1;
        in_data  = v1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 2*NW-1; c++) begin
            out_ready = ((c % 2) == 0);
            #1;
            check("t2_valid", 32'(out_valid), 32'd1);
            check("t2_data",  32'(out_data),  32'h0100 + 32'((c+1)/2));
            check("t2_last",  32'(out_last),  32'(((c+1)/2) == NW-1));
            tick();
        end
        check("t2_end_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // Back-to-back vectors with the second offered early
        in_valid = 1'b1;
        in_data  = v1;
        tick();
        in_data = v2;
        for (int c = 0; c < 2*NW; c++) begin
            if (c == NW) in_valid = 1'b0;
            #1;
            check("t3_valid", 32'(out_valid), 32'd1);
            check("t3_data",  32'(out_data),
                  (c < NW) ? 32'h0100 + 32'(c) : 32'h0200 + 32'(c-NW));
            check("t3_last",  32'(out_last),  32'(c == NW-1 || c == 2*NW-1));
            check("t3_ready", 32'(in_ready),  32'(c == NW-1 || c == 2*NW-1));
            tick();
        end
        check("t3_end_valid", 32'(out_valid), 32'd0);

        // New data offered mid-vector must be ignored
        in_valid = 1'b1;
        in_data  = v1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < NW; k++) begin
            if (k == 3) begin
                in_valid = 1'b1;
                in_data  = v2;
            end
            if (k == 20) in_valid = 1'b0;
            check("t4_data", 32'(out_data), 32'h0100 + 32'(k));
            tick();
        end
        check("t4_end_valid", 32'(out_valid), 32'd0);

        // Reset after ten words, then a fresh load restarts at word 0
        in_valid = 1'b1;
        in_data  = v1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("t5_pre_data", 32'(out_data), 32'h010A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t5_valid",    32'(out_valid), 32'd0);
        check("t5_busy",     32'(busy),      32'd0);
        check("t5_in_ready", 32'(in_ready),  32'd1);
        check("t5_data",     32'(out_data),  32'd0);
        tick();
        tick();
        check("t5_idle_valid", 32'(out_valid), 32'd0);
        lb       = '0;
        in_valid = 1'b1;
        in_data  = v2;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < NW; k++) begin
            check("t5_data_reload", 32'(out_data), 32'h0200 + 32'(k));
            tick();
        end
        check("t5_end_valid", 32'(out_valid), 32'd0);
        check_w("t5_loopback", lb, v2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
